// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-port memory between instruction fetch (port 0)
// and load/store (port 1). It keeps one read in flight and hides the fixed read latency.
module mem_port_arbiter #(
    parameter int AW  = 30,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [31:0]   wdata0,
    input  logic [31:0]   wdata1,
    input  logic [3:0]    wstrb0,
    input  logic [3:0]    wstrb1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [31:0]   rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic {IDLE, WAIT} state_e;

    localparam logic [3:0] CNT_START = 4'(LAT - 1);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        rvalid0_q, rvalid0_d;
    logic        rvalid1_q, rvalid1_d;
    logic [31:0] rdata_q, rdata_d;

    logic grant;
    logic grant_port;
    logic grant_we;

    // Arbitration is gated by rst_n so the memory side is quiet during reset.
    // NOTE: every signal written in an always_comb gets a default first; a missing branch would otherwise infer a latch.
    always_comb begin
        grant      = 1'b0;
        grant_port = 1'b0;
        if (rst_n && state_q == IDLE) begin
            if (req0 && req1) begin
                grant      = 1'b1;
                grant_port = ~last_q;
            end else if (req0) begin
                grant      = 1'b1;
                grant_port = 1'b0;
            end else if (req1) begin
                grant      = 1'b1;
                grant_port = 1'b1;
            end
        end
    end

    assign grant_we = grant_port ? we1 : we0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= 4'd0;
            owner_q   <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    last_d = grant_port;
                    // Writes complete in the grant cycle; only reads wait for data.
                    if (!grant_we) begin
                        owner_d = grant_port;
                        cnt_d   = CNT_START;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d   = mem_rdata;
                    rvalid0_d = ~owner_q;
                    rvalid1_d = owner_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt0      = grant & ~grant_port;
        gnt1      = grant & grant_port;
        mem_en    = grant;
        mem_we    = grant & grant_we;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        if (grant) begin
            mem_addr  = grant_port ? addr1 : addr0;
            mem_wdata = grant_port ? wdata1 : wdata0;
            // Byte strobes are meaningless on reads, so keep them off the macro.
            if (grant_we) begin
                mem_wstrb = grant_port ? wstrb1 : wstrb0;
            end
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (LAT = 1, 2, 3) with a latency-accurate memory model,
// per-port request queues and a read-return scoreboard for the instance under test.
module tb_mem_port_arbiter;

    localparam int AW = 30;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    wstrb;
    } txn_t;

    typedef struct {
        int          due;
        bit          port;
        logic [31:0] data;
    } rd_t;

    typedef struct {
        int cyc;
        bit port;
        bit we;
    } gl_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic          we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [31:0]   wdata0 = '0, wdata1 = '0;
    logic [3:0]    wstrb0 = '0, wstrb1 = '0;

    wire  [3:1]    gnt0_w, gnt1_w, rvalid0_w, rvalid1_w, mem_en_w, mem_we_w;
    wire  [31:0]   rdata_w     [1:3];
    wire  [AW-1:0] mem_addr_w  [1:3];
    wire  [31:0]   mem_wdata_w [1:3];
    wire  [3:0]    mem_wstrb_w [1:3];
    wire  [31:0]   mem_rdata_w [1:3];

    txn_t q0[$];
    txn_t q1[$];
    rd_t  sb[$];
    gl_t  glog[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base = 0;
    int sel = 2;

    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [AW-1:0] a);
        return (a == 30'h10) ? 32'hDEADBEEF : ({2'b00, a} ^ 32'h5A5A_0000);
    endfunction

    for (genvar k = 1; k <= 3; k++) begin : g_dut
        logic [AW-1:0] hist [0:15];

        mem_port_arbiter #(.AW(AW), .LAT(k)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .req0     (req0),
            .req1     (req1),
            .we0      (we0),
            .we1      (we1),
            .addr0    (addr0),
            .addr1    (addr1),
            .wdata0   (wdata0),
            .wdata1   (wdata1),
            .wstrb0   (wstrb0),
            .wstrb1   (wstrb1),
            .gnt0     (gnt0_w[k]),
            .gnt1     (gnt1_w[k]),
            .rvalid0  (rvalid0_w[k]),
            .rvalid1  (rvalid1_w[k]),
            .rdata    (rdata_w[k]),
            .mem_en   (mem_en_w[k]),
            .mem_we   (mem_we_w[k]),
            .mem_addr (mem_addr_w[k]),
            .mem_wdata(mem_wdata_w[k]),
            .mem_wstrb(mem_wstrb_w[k]),
            .mem_rdata(mem_rdata_w[k])
        );

        // Memory model: data for the address presented k cycles earlier.
        always @(posedge clk) begin
            hist[0] <= mem_addr_w[k];
            for (int i = 1; i < 16; i++) hist[i] <= hist[i-1];
        end
        assign mem_rdata_w[k] = mdata(hist[k-1]);
    end

    // Drives queued requests for n cycles and monitors the selected instance.
    task automatic run(input int n);
        logic g0, g1;
        bit   p, e0, e1;
        txn_t t;
        for (int k = 0; k < n; k++) begin
            req0 = (q0.size() > 0);
            req1 = (q1.size() > 0);
            if (req0) begin
                we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata; wstrb0 = q0[0].wstrb;
            end else begin
                we0 = 1'b0; addr0 = '0; wdata0 = '0; wstrb0 = '0;
            end
            if (req1) begin
                we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata; wstrb1 = q1[0].wstrb;
            end else begin
                we1 = 1'b0; addr1 = '0; wdata1 = '0; wstrb1 = '0;
            end
            @(negedge clk);
            g0 = gnt0_w[sel];
            g1 = gnt1_w[sel];
            checks++;
            if (g0 === 1'b1 && g1 === 1'b1) begin
                errors++;
                $display("FAIL both_gnt cyc=%0d got gnt0=%b gnt1=%b want one-hot", cyc, g0, g1);
            end
            checks++;
            if (mem_en_w[sel] !== (g0 | g1)) begin
                errors++;
                $display("FAIL mem_en cyc=%0d got %b want %b", cyc, mem_en_w[sel], g0 | g1);
            end
            if (g0 === 1'b1 || g1 === 1'b1) begin
                p = (g1 === 1'b1);
                checks++;
                if ((p ? q1.size() : q0.size()) == 0) begin
                    errors++;
                    $display("FAIL spurious_gnt cyc=%0d port=%0d got grant want none", cyc, p);
                end else begin
                    t = p ? q1[0] : q0[0];
                    checks++;
                    if ({mem_we_w[sel], mem_addr_w[sel], mem_wdata_w[sel], mem_wstrb_w[sel]} !==
                        {t.we, t.addr, t.wdata, (t.we ? t.wstrb : 4'b0000)}) begin
                        errors++;
                        $display("FAIL mem_cmd cyc=%0d got we=%b addr=%h wdata=%h wstrb=%b want we=%b addr=%h wdata=%h wstrb=%b",
                                 cyc, mem_we_w[sel], mem_addr_w[sel], mem_wdata_w[sel], mem_wstrb_w[sel],
                                 t.we, t.addr, t.wdata, (t.we ? t.wstrb : 4'b0000));
                    end
                    glog.push_back('{cyc - base, p, t.we});
                    if (!t.we) sb.push_back('{cyc + sel + 1, p, mdata(t.addr)});
                end
            end
            e0 = (sb.size() > 0) && (sb[0].due == cyc) && !sb[0].port;
            e1 = (sb.size() > 0) && (sb[0].due == cyc) && sb[0].port;
            checks++;
            if (rvalid0_w[sel] !== e0 || rvalid1_w[sel] !== e1) begin
                errors++;
                $display("FAIL rvalid cyc=%0d got rvalid0=%b rvalid1=%b want %b %b",
                         cyc, rvalid0_w[sel], rvalid1_w[sel], e0, e1);
            end else if (e0 || e1) begin
                checks++;
                if (rdata_w[sel] !== sb[0].data) begin
                    errors++;
                    $display("FAIL rdata cyc=%0d got %h want %h", cyc, rdata_w[sel], sb[0].data);
                end
            end
            if (e0 || e1) void'(sb.pop_front());
            @(posedge clk);
            #1;
            if (g0 === 1'b1 && q0.size() > 0) void'(q0.pop_front());
            if (g1 === 1'b1 && q1.size() > 0) void'(q1.pop_front());
            cyc++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete(); q1.delete(); sb.delete(); glog.delete();
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b1;
        addr0 = 30'h3; addr1 = 30'h4; wstrb1 = 4'hF;
        #2;
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if ({gnt0_w[k], gnt1_w[k], mem_en_w[k], mem_we_w[k], mem_wstrb_w[k], mem_addr_w[k]} !== '0) begin
                errors++;
                $display("FAIL reset_comb lat=%0d got gnt=%b%b en=%b we=%b want all 0",
                         k, gnt0_w[k], gnt1_w[k], mem_en_w[k], mem_we_w[k]);
            end
            checks++;
            if ({rvalid0_w[k], rvalid1_w[k], rdata_w[k]} !== '0) begin
                errors++;
                $display("FAIL reset_regs lat=%0d got rvalid=%b%b rdata=%h want 0",
                         k, rvalid0_w[k], rvalid1_w[k], rdata_w[k]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_read();
        sel = 2;
        do_reset();
        run(5);
        q0.push_back('{1'b0, 30'h10, 32'h1234_5678, 4'hF});
        run(6);
        checks++;
        if (glog.size() != 1) begin
            errors++;
            $display("FAIL single_read_count got %0d grants want 1", glog.size());
        end else begin
            checks++;
            if (glog[0].cyc != 5 || glog[0].port != 1'b0 || glog[0].we != 1'b0) begin
                errors++;
                $display("FAIL single_read_gnt got cyc=%0d port=%0d want cyc=5 port=0", glog[0].cyc, glog[0].port);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL single_read_pending got %0d outstanding want 0", sb.size());
        end
    endtask

    task automatic test_contention();
        int  ec[4] = '{0, 3, 6, 9};
        bit  ep[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        sel = 2;
        do_reset();
        q0.push_back('{1'b0, 30'h100, 32'h0, 4'h0});
        q0.push_back('{1'b0, 30'h101, 32'h0, 4'h0});
        q1.push_back('{1'b0, 30'h200, 32'h0, 4'h0});
        q1.push_back('{1'b0, 30'h201, 32'h0, 4'h0});
        run(14);
        checks++;
        if (glog.size() != 4) begin
            errors++;
            $display("FAIL contention_count got %0d grants want 4", glog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (glog[i].cyc != ec[i] || glog[i].port != ep[i]) begin
                    errors++;
                    $display("FAIL contention_gnt%0d got cyc=%0d port=%0d want cyc=%0d port=%0d",
                             i, glog[i].cyc, glog[i].port, ec[i], ep[i]);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL contention_pending got %0d outstanding want 0", sb.size());
        end
    endtask

    task automatic test_back_to_back_writes();
        sel = 2;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            q1.push_back('{1'b1, 30'h300 + 30'(i), $urandom, 4'b0011});
        end
        run(5);
        checks++;
        if (glog.size() != 3) begin
            errors++;
            $display("FAIL b2b_count got %0d grants want 3", glog.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (glog[i].cyc != i || glog[i].port != 1'b1 || glog[i].we != 1'b1) begin
                    errors++;
                    $display("FAIL b2b_gnt%0d got cyc=%0d port=%0d we=%0d want cyc=%0d port=1 we=1",
                             i, glog[i].cyc, glog[i].port, glog[i].we, i);
                end
            end
        end
    endtask

    task automatic test_read_then_write();
        sel = 2;
        do_reset();
        q0.push_back('{1'b0, 30'h55, 32'h0, 4'h0});
        run(1);
        q1.push_back('{1'b1, 30'h66, 32'hCAFE_F00D, 4'b1100});
        run(5);
        checks++;
        if (glog.size() != 2) begin
            errors++;
            $display("FAIL rtw_count got %0d grants want 2", glog.size());
        end else begin
            checks++;
            if (glog[1].cyc != 3 || glog[1].port != 1'b1) begin
                errors++;
                $display("FAIL rtw_gnt1 got cyc=%0d port=%0d want cyc=3 port=1", glog[1].cyc, glog[1].port);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        sel = 3;
        do_reset();
        q0.push_back('{1'b0, 30'h20, 32'h0, 4'h0});
        run(1);
        rst_n = 1'b0;
        sb.delete();
        glog.delete();
        q0.push_back('{1'b0, 30'h30, 32'h0, 4'h0});
        q1.push_back('{1'b0, 30'h40, 32'h0, 4'h0});
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        #1;
        checks++;
        if ({mem_en_w[3], gnt0_w[3], gnt1_w[3], mem_addr_w[3]} !== '0) begin
            errors++;
            $display("FAIL midread_async got en=%b gnt=%b%b addr=%h want 0",
                     mem_en_w[3], gnt0_w[3], gnt1_w[3], mem_addr_w[3]);
        end
        run(2);
        rst_n = 1'b1;
        base = cyc;
        run(12);
        checks++;
        if (glog.size() != 2) begin
            errors++;
            $display("FAIL midread_count got %0d grants want 2", glog.size());
        end else begin
            checks++;
            if (glog[0].cyc != 0 || glog[0].port != 1'b0 || glog[1].cyc != 4 || glog[1].port != 1'b1) begin
                errors++;
                $display("FAIL midread_tie got %0d/%0d %0d/%0d want 0/0 4/1",
                         glog[0].cyc, glog[0].port, glog[1].cyc, glog[1].port);
            end
        end
    endtask

    task automatic test_min_latency();
        int ec[3] = '{0, 2, 3};
        bit ew[3] = '{1'b0, 1'b1, 1'b0};
        sel = 1;
        do_reset();
        q0.push_back('{1'b0, 30'h60, 32'h0, 4'h0});
        q0.push_back('{1'b1, 30'h61, 32'hA5A5_0001, 4'b1111});
        q0.push_back('{1'b0, 30'h62, 32'h0, 4'h0});
        run(8);
        checks++;
        if (glog.size() != 3) begin
            errors++;
            $display("FAIL minlat_count got %0d grants want 3", glog.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (glog[i].cyc != ec[i] || glog[i].we != ew[i] || glog[i].port != 1'b0) begin
                    errors++;
                    $display("FAIL minlat_gnt%0d got cyc=%0d we=%0d want cyc=%0d we=%0d",
                             i, glog[i].cyc, glog[i].we, ec[i], ew[i]);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL minlat_pending got %0d outstanding want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back_writes();
        test_read_then_write();
        test_reset_mid_read();
        test_min_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
